// File: rtl/riscv_inst_encoder.sv
// riscv_inst_encoder: packs decoded RV32I instruction fields into 32-bit
// instruction words. Each immediate is range-checked. Legal words are queued
// in a small FIFO and leave it with sequential word-aligned byte addresses.
// Bundles that cannot be encoded are consumed, never queued, and counted.
//
// in_alu_op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL,
// 7 SRA, 8 OR, 9 AND. Codes 10..15 are unknown and cause a rejection.
module riscv_inst_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [3:0]        in_alu_op,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7;
  logic        alu_known;
  logic        alu_shift;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [31:0] enc_word;
  logic        enc_legal;

  logic [31:0]      mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             accept;
  logic             push;
  logic             pop;

  // Sign-extension checks: the bits above the field must all copy its top bit
  assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
  assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
  assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});

  // Translate the ALU operation into its funct3/funct7 pair
  always_comb begin
    alu_f3    = 3'b000;
    alu_f7    = 7'b0000000;
    alu_known = 1'b1;
    alu_shift = 1'b0;
    case (in_alu_op)
      ALU_ADD:  alu_f3 = 3'b000;
      ALU_SUB:  begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
      ALU_SLL:  begin alu_f3 = 3'b001; alu_shift = 1'b1; end
      ALU_SLT:  alu_f3 = 3'b010;
      ALU_SLTU: alu_f3 = 3'b011;
      ALU_XOR:  alu_f3 = 3'b100;
      ALU_SRL:  begin alu_f3 = 3'b101; alu_shift = 1'b1; end
      ALU_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; alu_shift = 1'b1; end
      ALU_OR:   alu_f3 = 3'b110;
      ALU_AND:  alu_f3 = 3'b111;
      default:  alu_known = 1'b0;
    endcase
  end

  // Pack the fields for the selected format and decide whether they are encodable
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (in_opcode)
      OP_R: begin
        enc_word  = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, in_opcode};
        enc_legal = alu_known;
      end
      OP_IMM: begin
        enc_word = {in_imm[11:0], in_rs1, alu_f3, in_rd, in_opcode};
        if (alu_shift) begin
          enc_legal = (in_imm[31:5] == {20'b0, alu_f7});
        end else begin
          enc_legal = alu_known && (in_alu_op != ALU_SUB) && fits12;
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_legal = fits12;
      end
      OP_STORE: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_legal = fits12;
      end
      OP_BRANCH: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_legal = fits13 && !in_imm[0];
      end
      OP_JAL: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_legal = fits21 && !in_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        enc_word  = {in_imm[31:12], in_rd, in_opcode};
        enc_legal = (in_imm[11:0] == 12'h000);
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign in_ready   = !fifo_full;
  assign out_valid  = !fifo_empty;
  assign out_instr  = fifo_empty ? 32'h0 : mem[rd_ptr[PTR_W-1:0]];
  assign accept     = in_valid && in_ready;
  assign push       = accept && enc_legal;
  assign pop        = out_valid && out_ready;

  // FIFO storage needs no reset; the pointers decide what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= enc_word;
    end
  end

  // FIFO pointers, output address counter and rejection reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_addr  <= BASE_ADDR;
      err       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + CNT_W'(1);
        out_addr <= out_addr + ADDR_W'(4);
      end
      err <= accept && !enc_legal;
      if (accept && !enc_legal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
